prog_loader: RTL
================

Name: prog_loader

Overview:
- Serial program loader that sits directly upstream of the CPU and its program memory.
- Consumes a byte stream from a UART receiver, deframes a program image, and writes it byte-by-byte into program memory.
- Holds the CPU in reset while loading; releases it only after a valid checksum.
- Replaces preloaded .mem images on hardware; benches can drive the same images through it.

Parameters:
- ADDR_WIDTH, 16, program memory address width; max image = 2**ADDR_WIDTH bytes.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 1_000_000, max clk cycles between consecutive bytes inside a frame.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- rx_valid  input  1  one-cycle strobe: rx_data holds a received byte
- rx_data  input  8  received byte
- mem_addr  output  ADDR_WIDTH  program memory write address
- mem_data  output  8  program memory write data
- mem_we  output  1  program memory write enable, one cycle per byte
- cpu_rst  output  1  reset to CPU, active-high
- loading  output  1  high while a frame is in progress
- load_done  output  1  high while the CPU is released (RUN)
- load_err  output  1  sticky error flag

Behaviour:
- Frame format: SYNC_BYTE, LEN_HI, LEN_LO, LEN data bytes, CSUM. LEN is big-endian 16-bit. CSUM = 8-bit sum mod 256 of data bytes only.
- States: IDLE, LEN_HI, LEN_LO, DATA, CSUM, RUN.
- Reset values:
  - State: IDLE.
  - cpu_rst=1.
  - mem_we=0, mem_addr=0, mem_data=0.
  - loading=0, load_done=0, load_err=0.
  - Internal count and sum = 0.
  - Reset mid-frame aborts the frame immediately. Already-written memory bytes are not undone.
- IDLE:
  - cpu_rst=1.
  - rx_valid with rx_data==SYNC_BYTE: go to LEN_HI, clear load_err, clear sum, set loading=1.
  - Any other byte is ignored.
- LEN_HI / LEN_LO: each accepted byte loads the length register.
  - At LEN_LO, LEN > 2**ADDR_WIDTH: set load_err=1, return to IDLE.
  - LEN==0: go to CSUM.
  - Otherwise go to DATA with index=0.
- DATA: on rx_valid, the next cycle has mem_we=1, mem_addr=index, mem_data=byte (registered, latency 1 cycle).
  - sum += byte (8-bit wrap); index increments.
  - After the LEN-th byte, go to CSUM.
  - mem_we is low in every other cycle and every other state.
- CSUM:
  - rx_data==sum: go to RUN. cpu_rst falls the following cycle; loading=0, load_done=1.
  - Mismatch: load_err=1, loading=0, go to IDLE. cpu_rst stays 1.
- RUN:
  - cpu_rst=0.
  - A SYNC_BYTE byte re-enters LEN_HI: cpu_rst=1 and load_done=0 from the next cycle, loading=1. This is the reload path.
  - Other bytes are ignored, so the CPU may receive its own data without disturbance.
- Timeout (LEN_HI..CSUM only): a gap counter clears on each rx_valid and increments otherwise.
  - Counter reaching TIMEOUT_CYCLES: load_err=1, loading=0, go to IDLE.
  - Counter saturates; it is idle outside a frame.
- rx_valid on consecutive cycles must be accepted without loss: one byte per cycle, one write per cycle.
- The image's last byte lands at address LEN-1. mem_addr holds its last value when mem_we=0.

Decomposition:
- Shared package bali_loader_pkg:
  - loader_state_e enum.
  - SYNC_BYTE default.
  - Frame field constants.
- One sub-module, loader_timeout: gap counter with clear/enable inputs and an expired output.
- Everything else is in prog_loader.

Test Plan:
- Good load: A5 00 03 11 22 33 66 → writes 0:11, 1:22, 2:33, exactly 3 mem_we pulses; cpu_rst falls, load_done=1, load_err=0.
- Bad checksum: A5 00 02 01 02 04 → 2 writes; load_err=1, cpu_rst stays 1, state IDLE. A following good frame clears load_err.
- Timeout (TIMEOUT_CYCLES=100 in bench): A5 00 05 01, then silence for 100 cycles → load_err=1, loading=0, cpu_rst=1.
- Noise and zero length: 00 FF 13 A5 00 00 00 → noise ignored, no mem_we, RUN entered.
- Reload and back-to-back: in RUN, send A5 00 02 AA BB 65 on consecutive cycles → cpu_rst=1 the cycle after A5, two writes, then RUN again.
- Reset mid-DATA: rst pulsed after 2 of 4 bytes → all outputs at reset values next cycle; a subsequent full frame loads correctly.
- End-to-end: a full .mem program image (e.g. intreverse) sent through the loader to the CPU → CPU terminates with op_code 8'h00.

Source files
------------

// File: rtl/bali_loader_pkg.sv
// Shared types and frame constants for the serial program loader.
package bali_loader_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned LEN_W  = 16;

  localparam logic [BYTE_W-1:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_RUN    = 3'd5
  } loader_state_e;

  // Running checksum: 8-bit sum that wraps modulo 256.
  function automatic logic [BYTE_W-1:0] csum_add(input logic [BYTE_W-1:0] acc,
                                                 input logic [BYTE_W-1:0] b);
    return BYTE_W'(acc + b);
  endfunction

endpackage

// File: rtl/loader_timeout.sv
// Saturating inter-byte gap counter; expired rises when the gap reaches LIMIT cycles.
module loader_timeout #(
  parameter int unsigned LIMIT = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  // expired is registered alongside cnt, so it asserts exactly when cnt hits LIMIT.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt     <= '0;
      expired <= 1'b0;
    end else if (en && !expired) begin
      cnt     <= CW'(cnt + CW'(1));
      expired <= (cnt == CW'(LIMIT - 1));
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Deframes a UART byte stream into program memory and gates CPU reset on a valid checksum.
module prog_loader
  import bali_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_data,
  output logic                  mem_we,
  output logic                  cpu_rst,
  output logic                  loading,
  output logic                  load_done,
  output logic                  load_err
);

  localparam logic [31:0] MAX_LEN = 32'd1 << ADDR_WIDTH;

  loader_state_e state, state_nxt;

  logic [LEN_W-1:0]      len, len_nxt, len_full;
  logic [LEN_W-1:0]      cnt, cnt_nxt;
  logic [BYTE_W-1:0]     sum, sum_nxt;
  logic [ADDR_WIDTH-1:0] mem_addr_nxt;
  logic [7:0]            mem_data_nxt;
  logic                  mem_we_nxt, cpu_rst_nxt, loading_nxt, load_done_nxt, load_err_nxt;
  logic                  is_sync, in_frame, tmo_expired;

  assign is_sync  = rx_valid && (rx_data == SYNC_BYTE);
  assign len_full = {len[LEN_W-1:BYTE_W], rx_data};
  assign in_frame = (state == ST_LEN_HI) || (state == ST_LEN_LO) ||
                    (state == ST_DATA)   || (state == ST_CSUM);

  // Gap counter only runs inside a frame; any received byte restarts it.
  loader_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (rx_valid || !in_frame),
    .en      (in_frame),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      len       <= '0;
      cnt       <= '0;
      sum       <= '0;
      mem_addr  <= '0;
      mem_data  <= '0;
      mem_we    <= 1'b0;
      cpu_rst   <= 1'b1;
      loading   <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      state     <= state_nxt;
      len       <= len_nxt;
      cnt       <= cnt_nxt;
      sum       <= sum_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_data  <= mem_data_nxt;
      mem_we    <= mem_we_nxt;
      cpu_rst   <= cpu_rst_nxt;
      loading   <= loading_nxt;
      load_done <= load_done_nxt;
      load_err  <= load_err_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    len_nxt       = len;
    cnt_nxt       = cnt;
    sum_nxt       = sum;
    mem_addr_nxt  = mem_addr;
    mem_data_nxt  = mem_data;
    mem_we_nxt    = 1'b0;
    cpu_rst_nxt   = cpu_rst;
    loading_nxt   = loading;
    load_done_nxt = load_done;
    load_err_nxt  = load_err;

    unique case (state)
      ST_IDLE: begin
        cpu_rst_nxt = 1'b1;
        if (is_sync) begin
          state_nxt    = ST_LEN_HI;
          load_err_nxt = 1'b0;
          sum_nxt      = '0;
          loading_nxt  = 1'b1;
        end
      end
      ST_LEN_HI: begin
        if (rx_valid) begin
          len_nxt   = {rx_data, len[BYTE_W-1:0]};
          state_nxt = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (rx_valid) begin
          len_nxt = len_full;
          cnt_nxt = '0;
          if (32'(len_full) > MAX_LEN) begin
            load_err_nxt = 1'b1;
            loading_nxt  = 1'b0;
            state_nxt    = ST_IDLE;
          end else if (len_full == '0) begin
            state_nxt = ST_CSUM;
          end else begin
            state_nxt = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (rx_valid) begin
          mem_we_nxt   = 1'b1;
          mem_addr_nxt = ADDR_WIDTH'(cnt);
          mem_data_nxt = rx_data;
          sum_nxt      = csum_add(sum, rx_data);
          cnt_nxt      = LEN_W'(cnt + LEN_W'(1));
          if (cnt == LEN_W'(len - LEN_W'(1))) state_nxt = ST_CSUM;
        end
      end
      ST_CSUM: begin
        if (rx_valid) begin
          loading_nxt = 1'b0;
          if (rx_data == sum) begin
            state_nxt     = ST_RUN;
            cpu_rst_nxt   = 1'b0;
            load_done_nxt = 1'b1;
          end else begin
            state_nxt    = ST_IDLE;
            load_err_nxt = 1'b1;
          end
        end
      end
      ST_RUN: begin
        cpu_rst_nxt = 1'b0;
        // Reload path: only a sync byte disturbs a running CPU.
        if (is_sync) begin
          state_nxt     = ST_LEN_HI;
          cpu_rst_nxt   = 1'b1;
          load_done_nxt = 1'b0;
          loading_nxt   = 1'b1;
          load_err_nxt  = 1'b0;
          sum_nxt       = '0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // A received byte in the same cycle takes priority over an expiring gap.
    if (in_frame && tmo_expired && !rx_valid) begin
      load_err_nxt = 1'b1;
      loading_nxt  = 1'b0;
      cpu_rst_nxt  = 1'b1;
      state_nxt    = ST_IDLE;
    end
  end

endmodule
